// File: rtl/sensor_arbiter.sv
// Round-robin arbiter that drains per-sensor one-deep hold registers onto a
// single FIFO write stream, counting samples dropped while a channel is still full.
module sensor_arbiter #(
  parameter int NUM_SENSORS = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [NUM_SENSORS*DATA_WIDTH-1:0] sensor_value,
  input  logic [NUM_SENSORS-1:0]            data_available,
  input  logic                              fifo_full,
  output logic [DATA_WIDTH-1:0]             sensor_value_out,
  output logic [ID_WIDTH-1:0]               sensor_id,
  output logic                              write,
  output logic [NUM_SENSORS-1:0]            pending,
  output logic [15:0]                       overflow_count
);

  localparam int CW = $clog2(NUM_SENSORS + 1);
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_SENSORS - 1);
  localparam logic [ID_WIDTH:0]   NUM_EXT = (ID_WIDTH + 1)'(NUM_SENSORS);

  logic [DATA_WIDTH-1:0]  hold_q [NUM_SENSORS];
  logic [DATA_WIDTH-1:0]  hold_d [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] pending_q, pending_d;
  logic [ID_WIDTH-1:0]    rr_q, rr_d;
  logic [DATA_WIDTH-1:0]  out_q, out_d;
  logic [ID_WIDTH-1:0]    id_q, id_d;
  logic                   write_q, write_d;
  logic [15:0]            ovf_q, ovf_d;

  logic                   grant_found_s;
  logic                   grant_s;
  logic [ID_WIDTH-1:0]    grant_id_s;
  logic [ID_WIDTH:0]      idx_s;
  logic [NUM_SENSORS-1:0] strobe_s;
  logic [NUM_SENSORS-1:0] grant_vec_s;
  logic [CW-1:0]          drops_s;
  logic [16:0]            ovf_sum_s;

  // Round-robin search: walking downward so the lowest offset from rr_q wins.
  always_comb begin
    grant_found_s = 1'b0;
    grant_id_s    = {ID_WIDTH{1'b0}};
    idx_s         = {(ID_WIDTH + 1){1'b0}};
    for (int k = NUM_SENSORS - 1; k >= 0; k--) begin
      idx_s = {1'b0, rr_q} + (ID_WIDTH + 1)'(k);
      if (idx_s >= NUM_EXT) begin
        idx_s = idx_s - NUM_EXT;
      end else begin
        idx_s = idx_s;
      end
      if (pending_q[idx_s[ID_WIDTH-1:0]]) begin
        grant_found_s = 1'b1;
        grant_id_s    = idx_s[ID_WIDTH-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  assign grant_s     = grant_found_s & ~fifo_full;
  assign strobe_s    = data_available & {NUM_SENSORS{enable}};
  assign grant_vec_s = grant_s ? (NUM_SENSORS'(1) << grant_id_s) : {NUM_SENSORS{1'b0}};

  // Hold-register capture, drain and drop accounting.
  always_comb begin
    hold_d    = hold_q;
    pending_d = pending_q;
    drops_s   = {CW{1'b0}};
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (strobe_s[i] && (!pending_q[i] || grant_vec_s[i])) begin
        hold_d[i]    = sensor_value[i*DATA_WIDTH +: DATA_WIDTH];
        pending_d[i] = 1'b1;
      end else if (strobe_s[i]) begin
        drops_s = drops_s + CW'(1);
      end else if (grant_vec_s[i]) begin
        pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end
    end
    ovf_sum_s = {1'b0, ovf_q} + 17'(drops_s);
    if (ovf_sum_s[16]) begin
      ovf_d = 16'hFFFF;
    end else begin
      ovf_d = ovf_sum_s[15:0];
    end
  end

  // Next values of the registered write port and the round-robin pointer.
  always_comb begin
    out_d   = out_q;
    id_d    = id_q;
    write_d = 1'b0;
    rr_d    = rr_q;
    if (grant_s) begin
      out_d   = hold_q[grant_id_s];
      id_d    = grant_id_s;
      write_d = 1'b1;
      if (grant_id_s == LAST_ID) begin
        rr_d = {ID_WIDTH{1'b0}};
      end else begin
        rr_d = grant_id_s + ID_WIDTH'(1);
      end
    end else begin
      write_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SENSORS; i++) begin
        hold_q[i] <= {DATA_WIDTH{1'b0}};
      end
      pending_q <= {NUM_SENSORS{1'b0}};
      rr_q      <= {ID_WIDTH{1'b0}};
      out_q     <= {DATA_WIDTH{1'b0}};
      id_q      <= {ID_WIDTH{1'b0}};
      write_q   <= 1'b0;
      ovf_q     <= 16'h0000;
    end else begin
      hold_q    <= hold_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      out_q     <= out_d;
      id_q      <= id_d;
      write_q   <= write_d;
      ovf_q     <= ovf_d;
    end
  end

  assign sensor_value_out = out_q;
  assign sensor_id        = id_q;
  assign write            = write_q;
  assign pending          = pending_q;
  assign overflow_count   = ovf_q;

endmodule

// File: tb/tb_sensor_arbiter.sv
// Directed bench for sensor_arbiter: reset, single, simultaneous, round-robin,
// backpressure/overflow, saturation and enable gating.
module tb_sensor_arbiter;

  localparam int N  = 8;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b1;
  logic [N*DW-1:0] sensor_value = '0;
  logic [N-1:0]    data_available = '0;
  logic            fifo_full = 1'b0;
  logic [DW-1:0]   sensor_value_out;
  logic [2:0]      sensor_id;
  logic            write;
  logic [N-1:0]    pending;
  logic [15:0]     overflow_count;

  int total = 0;
  int bad   = 0;

  sensor_arbiter #(.NUM_SENSORS(N), .DATA_WIDTH(DW), .ID_WIDTH(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .sensor_value     (sensor_value),
    .data_available   (data_available),
    .fifo_full        (fifo_full),
    .sensor_value_out (sensor_value_out),
    .sensor_id        (sensor_id),
    .write            (write),
    .pending          (pending),
    .overflow_count   (overflow_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_val(input int ch, input logic [31:0] v);
    sensor_value[ch*DW +: DW] = v;
  endtask

  initial begin
    // 1: reset held two edges, strobe during reset is ignored
    tick();
    data_available = 8'h08;
    set_val(3, 32'h3333_3333);
    tick();
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_ovf", 32'(overflow_count), 32'd0);
    data_available = 8'h00;
    reset = 1'b0;
    tick();
    chk("rel_value", sensor_value_out, 32'd0);
    chk("rel_id", 32'(sensor_id), 32'd0);
    chk("rel_write", 32'(write), 32'd0);
    chk("rel_pending", 32'(pending), 32'd0);

    // 2: single sample on ch5
    set_val(5, 32'hDEAD_BEEF);
    data_available = 8'h20;
    tick();
    chk("single_pend_n", 32'(pending), 32'h20);
    chk("single_write_n", 32'(write), 32'd0);
    data_available = 8'h00;
    tick();
    chk("single_write", 32'(write), 32'd1);
    chk("single_value", sensor_value_out, 32'hDEAD_BEEF);
    chk("single_id", 32'(sensor_id), 32'd5);
    chk("single_pend", 32'(pending), 32'd0);
    tick();
    chk("single_idle", 32'(write), 32'd0);

    // 3: all eight at once, rr pointer back at 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_val(i, 32'h100 + 32'(i));
    data_available = 8'hFF;
    tick();
    chk("simul_pend", 32'(pending), 32'hFF);
    chk("simul_nowrite", 32'(write), 32'd0);
    data_available = 8'h00;
    for (int k = 0; k < N; k++) begin
      tick();
      chk("simul_write", 32'(write), 32'd1);
      chk("simul_id", 32'(sensor_id), 32'(k));
      chk("simul_value", sensor_value_out, 32'h100 + 32'(k));
    end
    chk("simul_pend_done", 32'(pending), 32'd0);
    chk("simul_ovf", 32'(overflow_count), 32'd0);
    tick();
    chk("simul_idle", 32'(write), 32'd0);

    // 4: ch2 and ch6 strobing together every other cycle alternate 2,6,2,6
    for (int r = 0; r < 4; r++) begin
      set_val(2, 32'h200 + 32'(r));
      set_val(6, 32'h600 + 32'(r));
      data_available = 8'h44;
      tick();
      if (r > 0) begin
        chk("rr_id6", 32'(sensor_id), 32'd6);
        chk("rr_val6", sensor_value_out, 32'h600 + 32'(r - 1));
        chk("rr_wr6", 32'(write), 32'd1);
      end else begin
        chk("rr_first_nowrite", 32'(write), 32'd0);
      end
      data_available = 8'h00;
      tick();
      chk("rr_id2", 32'(sensor_id), 32'd2);
      chk("rr_val2", sensor_value_out, 32'h200 + 32'(r));
      chk("rr_wr2", 32'(write), 32'd1);
    end
    tick();
    chk("rr_last_id", 32'(sensor_id), 32'd6);
    chk("rr_last_val", sensor_value_out, 32'h603);
    chk("rr_ovf", 32'(overflow_count), 32'd0);

    // 5: fifo full, three strobes on ch1 -> two drops, then first value drains
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fifo_full = 1'b1;
    data_available = 8'h02;
    set_val(1, 32'h11);
    tick();
    chk("bp_wr1", 32'(write), 32'd0);
    set_val(1, 32'h22);
    tick();
    chk("bp_wr2", 32'(write), 32'd0);
    chk("bp_ovf2", 32'(overflow_count), 32'd1);
    set_val(1, 32'h33);
    tick();
    chk("bp_wr3", 32'(write), 32'd0);
    chk("bp_ovf3", 32'(overflow_count), 32'd2);
    chk("bp_pend", 32'(pending), 32'h02);
    data_available = 8'h00;
    fifo_full = 1'b0;
    tick();
    chk("bp_drain_wr", 32'(write), 32'd1);
    chk("bp_drain_val", sensor_value_out, 32'h11);
    chk("bp_drain_id", 32'(sensor_id), 32'd1);
    tick();
    chk("bp_once", 32'(write), 32'd0);
    chk("bp_pend_done", 32'(pending), 32'd0);

    // 6: eight drops per cycle until saturation, then enable gating
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fifo_full = 1'b1;
    for (int i = 0; i < N; i++) set_val(i, 32'h6000 + 32'(i));
    data_available = 8'hFF;
    tick();
    chk("sat_capture", 32'(pending), 32'hFF);
    chk("sat_ovf0", 32'(overflow_count), 32'd0);
    for (int k = 0; k < 8191; k++) tick();
    chk("sat_fff8", 32'(overflow_count), 32'hFFF8);
    tick();
    chk("sat_clamp", 32'(overflow_count), 32'hFFFF);
    for (int k = 0; k < 560; k++) tick();
    chk("sat_hold", 32'(overflow_count), 32'hFFFF);
    chk("sat_nowrite", 32'(write), 32'd0);
    for (int i = 0; i < N; i++) set_val(i, 32'hBAD0 + 32'(i));
    enable = 1'b0;
    fifo_full = 1'b0;
    for (int k = 0; k < N; k++) begin
      tick();
      chk("en_drain_wr", 32'(write), 32'd1);
      chk("en_drain_id", 32'(sensor_id), 32'(k));
      chk("en_drain_val", sensor_value_out, 32'h6000 + 32'(k));
    end
    tick();
    chk("en_nocapture", 32'(pending), 32'd0);
    chk("en_nowrite", 32'(write), 32'd0);
    chk("en_ovf", 32'(overflow_count), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
